// File: rtl/cpu_sequencer.sv
// Program loader and run controller for the 9-bit cpu core: assembles 3-bit beats into
// instructions, then runs/halts the cpu. Optional watchdog compiled in with SEQ_WATCHDOG_EN.
module cpu_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int WDOG_MAX   = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [2:0]        LOAD_DATA,
    input  logic              LOAD_VALID,
    input  logic              START,
    input  logic              STOP,
    input  logic              CLEAR,
    input  logic [8:0]        CPU_PC,
    output logic [8:0]        CPU_INSTRUCTION,
    output logic              CPU_WRITE_EN,
    output logic              CPU_CS,
    output logic              CPU_RD,
    output logic              CPU_RESET,
    output logic [1:0]        STATE,
    output logic [ADDR_W:0]   PROG_LEN,
    output logic              DONE,
    output logic              OVERFLOW
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PROG_DEPTH);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  prog_len_q, prog_len_d;
    logic [1:0]        beat_cnt_q, beat_cnt_d;
    logic [5:0]        beat_buf_q, beat_buf_d;
    logic              overflow_q, overflow_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              cpu_en_q, cpu_en_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [8:0]        mem_wdata;
    logic [8:0]        mem [PROG_DEPTH];

    logic              run_checked;
    logic              pc_past_end;
    logic              wdog_expire;
    logic              wdog_flag;

    // cpu_en_q is only set after the first RUN cycle, so it doubles as the halt-check qualifier
    assign run_checked = (state_q == S_RUN) && cpu_en_q;
    assign pc_past_end = 32'(CPU_PC) >= 32'(prog_len_q);

`ifdef SEQ_WATCHDOG_EN
    localparam int WDOG_W = (WDOG_MAX < 256) ? 8 : $clog2(WDOG_MAX + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_flag_q, wdog_flag_d;

    assign wdog_expire = (state_q == S_RUN) && (wdog_cnt_q == WDOG_W'(WDOG_MAX - 1));
    assign wdog_flag   = wdog_flag_q;

    always_comb begin
        wdog_cnt_d  = (state_q == S_RUN) ? wdog_cnt_q + 1'b1 : '0;
        wdog_flag_d = wdog_flag_q;
        if (CLEAR && state_q != S_RUN) begin
            wdog_flag_d = 1'b0;
        end else if (run_checked && wdog_expire) begin
            wdog_flag_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wdog_cnt_q  <= '0;
            wdog_flag_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_flag_q <= wdog_flag_d;
        end
    end
`else
    // Budget parameter has no effect without the watchdog; this term is constant false
    assign wdog_expire = (WDOG_MAX < 0);
    assign wdog_flag   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        beat_cnt_d = beat_cnt_q;
        beat_buf_d = beat_buf_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_waddr  = prog_len_q[ADDR_W-1:0];
        mem_wdata  = {beat_buf_q, LOAD_DATA};

        if (CLEAR && state_q != S_RUN) begin
            state_d    = S_IDLE;
            prog_len_d = '0;
            beat_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (!STOP) begin
                        if (START) begin
                            if (prog_len_q != '0) begin
                                state_d    = S_RUN;
                                beat_cnt_d = '0;
                            end
                        end else if (LOAD_VALID) begin
                            state_d = S_LOAD;
                            if (prog_len_q == FULL_LEN) begin
                                overflow_d = 1'b1;
                            end else if (beat_cnt_q == 2'd2) begin
                                mem_we     = 1'b1;
                                prog_len_d = prog_len_q + 1'b1;
                                beat_cnt_d = '0;
                            end else begin
                                beat_buf_d = {beat_buf_q[2:0], LOAD_DATA};
                                beat_cnt_d = beat_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (run_checked && (STOP || pc_past_end || wdog_expire)) begin
                        state_d = S_HALT;
                    end
                end
                S_HALT: begin
                    if (!STOP && START && prog_len_q != '0) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // cpu is held in reset while loading and for the first RUN cycle after entry
        cpu_reset_d = (state_d == S_IDLE) || (state_d == S_LOAD) ||
                      (state_d == S_RUN && state_q != S_RUN);
        cpu_en_d    = (state_d == S_RUN) && (state_q == S_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            prog_len_q  <= '0;
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            cpu_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_len_q  <= prog_len_d;
            beat_cnt_q  <= beat_cnt_d;
            overflow_q  <= overflow_d;
            cpu_reset_q <= cpu_reset_d;
            cpu_en_q    <= cpu_en_d;
        end
        beat_buf_q <= beat_buf_d;
    end

    always_ff @(posedge CLK) begin
        if (mem_we && !RESET) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign CPU_INSTRUCTION = run_checked ? mem[CPU_PC[ADDR_W-1:0]] : '0;
    assign CPU_CS          = cpu_en_q;
    assign CPU_RD          = cpu_en_q;
    assign CPU_WRITE_EN    = cpu_en_q;
    assign CPU_RESET       = cpu_reset_q;
    assign STATE           = state_q;
    assign PROG_LEN        = prog_len_q;
    assign DONE            = (state_q == S_HALT);
    assign OVERFLOW        = overflow_q | wdog_flag;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: each driven cycle pushes its expected outputs,
// which are popped and compared after the following clock edge.
module tb_cpu_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;
`ifdef SEQ_WATCHDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET, LOAD_VALID, START, STOP, CLEAR;
    logic [2:0] LOAD_DATA;
    logic [8:0] CPU_PC;
    logic [8:0] CPU_INSTRUCTION;
    logic       CPU_WRITE_EN, CPU_CS, CPU_RD, CPU_RESET, DONE, OVERFLOW;
    logic [1:0] STATE;
    logic [4:0] PROG_LEN;

    cpu_sequencer #(.PROG_DEPTH(16), .ADDR_W(4), .WDOG_MAX(255)) dut (
        .CLK(CLK), .RESET(RESET), .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID),
        .START(START), .STOP(STOP), .CLEAR(CLEAR), .CPU_PC(CPU_PC),
        .CPU_INSTRUCTION(CPU_INSTRUCTION), .CPU_WRITE_EN(CPU_WRITE_EN), .CPU_CS(CPU_CS),
        .CPU_RD(CPU_RD), .CPU_RESET(CPU_RESET), .STATE(STATE), .PROG_LEN(PROG_LEN),
        .DONE(DONE), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] st;
        int         len;
        logic       ovf;
        logic       done;
        logic       crst;
        logic       cs;
        logic       chk;
        logic [8:0] ins;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] st, input int len, input logic ovf,
                                input logic done, input logic crst, input logic cs,
                                input logic chk, input logic [8:0] ins);
        exp_t e;
        e.st = st; e.len = len; e.ovf = ovf; e.done = done;
        e.crst = crst; e.cs = cs; e.chk = chk; e.ins = ins;
        return e;
    endfunction

    // Drive one cycle of inputs; instruction is sampled mid-cycle, registered outputs after the edge
    task automatic cyc(input logic rs, input logic cl, input logic sp, input logic go,
                       input logic lv, input logic [2:0] d, input logic [8:0] pc, input exp_t e);
        exp_t       x;
        logic [8:0] ins_seen;
        RESET = rs; CLEAR = cl; STOP = sp; START = go;
        LOAD_VALID = lv; LOAD_DATA = d; CPU_PC = pc;
        sb_q.push_back(e);
        #1 ins_seen = CPU_INSTRUCTION;
        @(posedge CLK);
        #1;
        x = sb_q.pop_front();
        if (x.chk) check_val("instr", 32'(ins_seen), 32'(x.ins));
        check_val("state", 32'(STATE), 32'(x.st));
        check_val("prog_len", 32'(PROG_LEN), x.len);
        check_val("overflow", 32'(OVERFLOW), 32'(x.ovf));
        check_val("done", 32'(DONE), 32'(x.done));
        check_val("cpu_reset", 32'(CPU_RESET), 32'(x.crst));
        check_val("cs", 32'(CPU_CS), 32'(x.cs));
        check_val("rd", 32'(CPU_RD), 32'(x.cs));
        check_val("write_en", 32'(CPU_WRITE_EN), 32'(x.cs));
    endtask

    task automatic beat(input logic [2:0] d, input exp_t e);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d, 9'd0, e);
    endtask

    task automatic pc_cyc(input logic sp, input logic go, input logic [8:0] pc, input exp_t e);
        cyc(1'b0, 1'b0, sp, go, 1'b0, 3'd0, pc, e);
    endtask

    initial begin
        // reset
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, mk(S_IDLE, 0, 0, 0, 1, 0, 0, 9'd0));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, mk(S_IDLE, 0, 0, 0, 1, 0, 0, 9'd0));
        // START with empty program, and START+STOP in IDLE: both ignored
        pc_cyc(1'b0, 1'b1, 9'd0, mk(S_IDLE, 0, 0, 0, 1, 0, 0, 9'd0));
        pc_cyc(1'b1, 1'b1, 9'd0, mk(S_IDLE, 0, 0, 0, 1, 0, 0, 9'd0));

        // load two instructions: 9'h157, 9'h00C
        beat(3'b101, mk(S_LOAD, 0, 0, 0, 1, 0, 0, 9'd0));
        beat(3'b010, mk(S_LOAD, 0, 0, 0, 1, 0, 0, 9'd0));
        beat(3'b111, mk(S_LOAD, 1, 0, 0, 1, 0, 0, 9'd0));
        beat(3'b000, mk(S_LOAD, 1, 0, 0, 1, 0, 0, 9'd0));
        beat(3'b001, mk(S_LOAD, 1, 0, 0, 1, 0, 0, 9'd0));
        beat(3'b100, mk(S_LOAD, 2, 0, 0, 1, 0, 0, 9'd0));
        // STOP outranks START in LOAD
        pc_cyc(1'b1, 1'b1, 9'd0, mk(S_LOAD, 2, 0, 0, 1, 0, 0, 9'd0));

        // run PC 0,0,1,2 -> halt when PC reaches PROG_LEN
        pc_cyc(1'b0, 1'b1, 9'd0, mk(S_RUN, 2, 0, 0, 1, 0, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'd0, mk(S_RUN, 2, 0, 0, 0, 1, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'd0, mk(S_RUN, 2, 0, 0, 0, 1, 1, 9'h157));
        pc_cyc(1'b0, 1'b0, 9'd1, mk(S_RUN, 2, 0, 0, 0, 1, 1, 9'h00C));
        pc_cyc(1'b0, 1'b0, 9'd2, mk(S_HALT, 2, 0, 1, 0, 0, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'd2, mk(S_HALT, 2, 0, 1, 0, 0, 1, 9'd0));

        // restart from HALT, STOP on RUN cycle 3
        pc_cyc(1'b0, 1'b1, 9'd0, mk(S_RUN, 2, 0, 0, 1, 0, 1, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'd0, mk(S_RUN, 2, 0, 0, 0, 1, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'd0, mk(S_RUN, 2, 0, 0, 0, 1, 1, 9'h157));
        pc_cyc(1'b1, 1'b0, 9'd0, mk(S_HALT, 2, 0, 1, 0, 0, 1, 9'h157));

        // CLEAR and LOAD_VALID ignored in RUN, then RESET mid-RUN
        pc_cyc(1'b0, 1'b1, 9'd0, mk(S_RUN, 2, 0, 0, 1, 0, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'd0, mk(S_RUN, 2, 0, 0, 0, 1, 0, 9'd0));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 9'd0, mk(S_RUN, 2, 0, 0, 0, 1, 1, 9'h157));
        pc_cyc(1'b0, 1'b0, 9'd1, mk(S_RUN, 2, 0, 0, 0, 1, 1, 9'h00C));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd1, mk(S_IDLE, 0, 0, 0, 1, 0, 1, 9'h00C));

        // fill all 16 slots (beat data = index mod 8), 49th beat overflows
        for (int i = 0; i < 48; i++) begin
            beat(3'(i % 8), mk(S_LOAD, (i + 1) / 3, 0, 0, 1, 0, 0, 9'd0));
        end
        beat(3'b011, mk(S_LOAD, 16, 1, 0, 1, 0, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'd0, mk(S_LOAD, 16, 1, 0, 1, 0, 0, 9'd0));
        // last slot holds beats 45,46,47 = 5,6,7 -> 9'h177; PC 16 ends the program
        pc_cyc(1'b0, 1'b1, 9'd15, mk(S_RUN, 16, 1, 0, 1, 0, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'd15, mk(S_RUN, 16, 1, 0, 0, 1, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'd15, mk(S_RUN, 16, 1, 0, 0, 1, 1, 9'h177));
        pc_cyc(1'b0, 1'b0, 9'd16, mk(S_HALT, 16, 1, 1, 0, 0, 0, 9'd0));
        // PC far beyond the array whose low bits alias a valid slot still halts
        pc_cyc(1'b0, 1'b1, 9'd0, mk(S_RUN, 16, 1, 0, 1, 0, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'h105, mk(S_RUN, 16, 1, 0, 0, 1, 0, 9'd0));
        pc_cyc(1'b0, 1'b0, 9'h105, mk(S_HALT, 16, 1, 1, 0, 0, 0, 9'd0));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, mk(S_IDLE, 0, 0, 0, 1, 0, 0, 9'd0));

        // long run with PC stuck at 0
        beat(3'b101, mk(S_LOAD, 0, 0, 0, 1, 0, 0, 9'd0));
        beat(3'b010, mk(S_LOAD, 0, 0, 0, 1, 0, 0, 9'd0));
        beat(3'b111, mk(S_LOAD, 1, 0, 0, 1, 0, 0, 9'd0));
        pc_cyc(1'b0, 1'b1, 9'd0, mk(S_RUN, 1, 0, 0, 1, 0, 0, 9'd0));
        for (int c = 1; c <= 300; c++) begin
            logic h;
            h = WDOG && (c >= 255);
            pc_cyc(1'b0, 1'b0, 9'd0,
                   mk(h ? S_HALT : S_RUN, 1, h, h, 1'b0, !h, (c >= 2 && c <= 255), 9'h157));
        end
        pc_cyc(1'b1, 1'b0, 9'd0, mk(S_HALT, 1, WDOG, 1, 0, 0, 0, 9'd0));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, mk(S_IDLE, 0, 0, 0, 1, 0, 0, 9'd0));

        check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
